// File: rtl/cond_logic_mc_pkg.sv
// Shared constants for the multicycle ARM conditional-execution unit:
// condition-code encodings and NZCV flag bit positions.
package cond_logic_mc_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_logic_mc_cond_check.sv
// Purely combinational evaluation of a 4-bit ARM condition field against
// a set of {N,Z,C,V} flags.
module cond_check
  import cond_logic_mc_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n_s, z_s, c_s, v_s, ge_s;

  assign n_s  = Flags[FLAG_N];
  assign z_s  = Flags[FLAG_Z];
  assign c_s  = Flags[FLAG_C];
  assign v_s  = Flags[FLAG_V];
  assign ge_s = (n_s == v_s);

  // Condition decode; the unconditional space (NV) is treated as never.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z_s;
      COND_NE: CondEx = ~z_s;
      COND_CS: CondEx = c_s;
      COND_CC: CondEx = ~c_s;
      COND_MI: CondEx = n_s;
      COND_PL: CondEx = ~n_s;
      COND_VS: CondEx = v_s;
      COND_VC: CondEx = ~v_s;
      COND_HI: CondEx = c_s & ~z_s;
      COND_LS: CondEx = ~c_s | z_s;
      COND_GE: CondEx = ge_s;
      COND_LT: CondEx = ~ge_s;
      COND_GT: CondEx = ~z_s & ge_s;
      COND_LE: CondEx = z_s | ~ge_s;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_mc.sv
// Conditional-execution unit for the multicycle ARM datapath: stores NZCV,
// latches the per-instruction condition result and gates write strobes.
// Optional feature macro: COND_FLAG_FWD_EN (same-cycle flag bypass into CondEx).
module cond_logic_mc
  import cond_logic_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondCapture,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       CondExReg
);

  logic [3:0] flags_r;
  logic       cond_ex_r;
  logic [1:0] flag_write_s;
  logic [3:0] eval_flags_s;
  logic       cond_ex_s;

  // FlagWrite depends only on the registered result, so the bypass below is loop-free.
  assign flag_write_s = FlagW & {2{cond_ex_r}};

`ifdef COND_FLAG_FWD_EN
  assign eval_flags_s[FLAG_N:FLAG_Z] = flag_write_s[1] ? ALUFlags[FLAG_N:FLAG_Z]
                                                       : flags_r[FLAG_N:FLAG_Z];
  assign eval_flags_s[FLAG_C:FLAG_V] = flag_write_s[0] ? ALUFlags[FLAG_C:FLAG_V]
                                                       : flags_r[FLAG_C:FLAG_V];
`else
  assign eval_flags_s = flags_r;
`endif

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (eval_flags_s),
    .CondEx (cond_ex_s)
  );

  // Flag halves and the latched condition result; reset overrides capture and writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r   <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      if (flag_write_s[1]) begin
        flags_r[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end
      if (flag_write_s[0]) begin
        flags_r[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
      if (CondCapture) begin
        cond_ex_r <= cond_ex_s;
      end
    end
  end

  // Strobes are masked while reset is high so they are clean before the first edge.
  assign PCWrite   = (PCS & cond_ex_r & ~reset) | NextPC;
  assign RegWrite  = RegW & cond_ex_r & ~reset;
  assign MemWrite  = MemW & cond_ex_r & ~reset;
  assign Flags     = flags_r;
  assign CondEx    = cond_ex_s;
  assign CondExReg = cond_ex_r;

endmodule

// File: doc/cond_logic_mc.md
# cond_logic_mc

Conditional-execution unit for the multicycle ARM datapath, directly downstream of the ALU. It stores the NZCV flags produced by the ALU and evaluates each instruction's 4-bit condition field against the stored flags. It latches the pass/fail result for the rest of the instruction, and gates the controller's PC, register-file, memory and flag write strobes with that result.

## Interface
- No parameters. Widths are fixed by the ISA.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Cond  input  4  instruction condition field (Instr[31:28]).
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle.
- FlagW  input  2  flag-write request: [1] writes N,Z; [0] writes C,V.
- CondCapture  input  1  one-cycle pulse from the main FSM in Decode; latches the condition result.
- PCS  input  1  instruction writes the PC (branch or Rd=R15).
- NextPC  input  1  FSM PC increment (Fetch); never gated.
- RegW  input  1  register-file write request.
- MemW  input  1  memory write request.
- PCWrite  output  1  PCS&CondExReg | NextPC.
- RegWrite  output  1  RegW&CondExReg.
- MemWrite  output  1  MemW&CondExReg.
- Flags  output  4  stored {N,Z,C,V}.
- CondEx  output  1  combinational result of Cond against the evaluation flags.
- CondExReg  output  1  latched condition result for the current instruction.

## Operation
- Condition map, with n,z,c,v the evaluation flags:
  - 0000 EQ z; 0001 NE !z; 0010 CS c; 0011 CC !c.
  - 0100 MI n; 0101 PL !n; 0110 VS v; 0111 VC !v.
  - 1000 HI c&!z; 1001 LS !c|z.
  - 1010 GE n==v; 1011 LT n!=v; 1100 GT !z&(n==v); 1101 LE z|(n!=v).
  - 1110 AL 1; 1111 0 (unconditional space not supported; evaluates as never).
- Flag write enables: FlagWrite[1] = FlagW[1]&CondExReg; FlagWrite[0] = FlagW[0]&CondExReg.
- On a rising edge with FlagWrite[1], Flags[3:2] <= ALUFlags[3:2]. With FlagWrite[0], Flags[1:0] <= ALUFlags[1:0]. The two halves update independently.
- On a rising edge with CondCapture, CondExReg <= CondEx. Otherwise CondExReg holds.
- Failed condition (CondExReg=0): RegWrite, MemWrite and both flag writes are suppressed. PCWrite follows NextPC only.
- Output gating is combinational. The outputs change in the same cycle as the request inputs.

## Timing
- Reset (synchronous): Flags=4'b0000 and CondExReg=0. While reset is high, PCWrite=NextPC and RegWrite=MemWrite=0.
- CondCapture latency: CondEx is sampled at the capture edge, and CondExReg is valid from the next cycle onward.
- Flag update latency: the update is visible on Flags one cycle after the write edge.
- CondCapture and a flag write in the same cycle: the capture uses the evaluation flags defined under Configuration. The flag write is gated by the old CondExReg.
- Reset asserted mid-instruction: it overrides both CondCapture and flag writes in that cycle.
- CondExReg persists across instructions until the next CondCapture. The FSM must pulse CondCapture once per instruction.

## Configuration
- COND_FLAG_FWD_EN defined: the evaluation flags are Flags with each half replaced by ALUFlags when the corresponding FlagWrite bit is set in that cycle. This bypasses a same-cycle flag update into CondEx. It is loop-free because FlagWrite depends only on the registered CondExReg.
- COND_FLAG_FWD_EN undefined: the evaluation flags are the registered Flags only.

## Structure
- Shared package holds:
  - the condition-code constants (COND_EQ … COND_AL, COND_NV);
  - the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, cond_check, is purely combinational: inputs Cond and {n,z,c,v}, output CondEx.
- The flag registers, CondExReg and the write gating live in the top module.

## Test plan
- Reset: hold reset with NextPC=1, RegW=1 and FlagW=11 with ALUFlags=1111. Required: Flags=0000, CondExReg=0, PCWrite=1, RegWrite=0.
- Partial flag write: CondExReg=1, FlagW=10, ALUFlags=1111 from Flags=0000. Required: Flags=1100 next cycle. Then FlagW=01, ALUFlags=0000. Required: Flags=1100 (C,V already 0, unchanged).
- Condition sweep: for each Flags value in {0000, 0100, 0010, 1001, 1000}, step Cond through all 16 codes. Required: CondEx matches the map, including 1111=0 and 1110=1.
- Failed condition: Flags=0000, Cond=0000 (EQ), CondCapture pulse, then PCS=RegW=MemW=1 and FlagW=11. Required: PCWrite=0, RegWrite=0, MemWrite=0, Flags unchanged.
- Same-cycle capture and write: CondExReg=1, Flags=0000, FlagW=10, ALUFlags=0100, Cond=EQ, CondCapture=1.
  - With COND_FLAG_FWD_EN: required CondExReg=1.
  - Without COND_FLAG_FWD_EN: required CondExReg=0.
- Reset mid-instruction: CondExReg=1 with CondCapture=1 and reset=1 in the same cycle. Required: CondExReg=0 and Flags=0000 next cycle.
